// File: rtl/gb_debug_display_pkg.sv
// Shared definitions for the debug display: segment bit positions, the
// debounce FSM state type, the hex font and a width helper.
package gb_dbg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef enum logic {
        DB_STABLE = 1'b0,
        DB_CHECK  = 1'b1
    } db_state_e;

    // Ceiling log2, never below 1 so single-value counters still get a bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Active-high segment pattern, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/gb_debug_display_if.sv
// Signal bundle between the FPGA top level and the debug display engine.
// There is no handshake: inputs are sampled every cycle, outputs are registered levels.
interface gb_debug_display_if
    import gb_dbg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int N_CH     = 4
) ();

    localparam int DW = 4 * N_DIGITS;
    localparam int CW = clog2_min1(N_CH);

    logic [N_CH*DW-1:0]  ch_data;
    logic                btn_next;
    logic                freeze;
    logic [N_DIGITS-1:0] seg_an;
    logic [7:0]          seg_cat;
    logic [CW-1:0]       cur_ch;
    logic                btn_level;
    db_state_e           btn_state;

    modport master (
        output ch_data, btn_next, freeze,
        input  seg_an, seg_cat, cur_ch, btn_level, btn_state
    );

    modport slave (
        input  ch_data, btn_next, freeze,
        output seg_an, seg_cat, cur_ch, btn_level, btn_state
    );

endinterface

// File: rtl/gb_debug_display_btn.sv
// Push-button conditioner: 2-FF synchroniser feeding a STABLE/CHECK debounce
// FSM; an accepted rising level produces a one-cycle press pulse.
module gb_btn_debounce
    import gb_dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      btn_raw,
    output logic      level,
    output logic      press,
    output db_state_e state
);

    localparam int              CNTW     = clog2_min1(DEBOUNCE_CYC);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE_CYC - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic [CNTW-1:0] cnt_q;
    logic            level_q;
    logic            press_q;
    db_state_e       state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            state_q <= DB_STABLE;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            case (state_q)
                DB_STABLE: begin
                    if (sync2_q != level_q) begin
                        state_q <= DB_CHECK;
                        cnt_q   <= '0;
                    end
                end
                DB_CHECK: begin
                    if (sync2_q == level_q) begin
                        state_q <= DB_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        // Only the 0->1 acceptance counts as a press.
                        level_q <= sync2_q;
                        press_q <= sync2_q;
                        state_q <= DB_STABLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= DB_STABLE;
            endcase
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign state = state_q;

endmodule

// File: rtl/gb_debug_display.sv
// Debug display engine: picks one CPU debug word, optionally freezes it, and
// scans it as hex onto a multiplexed 7-segment display with anti-ghost blanking.
module gb_debug_display
    import gb_dbg_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int N_CH           = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 500,
    parameter int DEBOUNCE_CYC   = 1000000,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit CAT_ACTIVE_LOW = 1'b1
) (
    input logic              clk,
    input logic              rst,
    gb_debug_display_if.slave bus
);

    localparam int DW  = 4 * N_DIGITS;
    localparam int CW  = clog2_min1(N_CH);
    localparam int PW  = clog2_min1(SCAN_DIV);
    localparam int DGW = clog2_min1(N_DIGITS);

    localparam logic [PW-1:0]       PS_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]       BLANK_LIM = PW'(BLANK_CYC);
    localparam logic [DGW-1:0]      DG_LAST   = DGW'(N_DIGITS - 1);
    localparam logic [CW-1:0]       CH_LAST   = CW'(N_CH - 1);
    // XOR masks turning active-high patterns into pin levels; also the "all off" value.
    localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [7:0]          CAT_OFF   = {8{CAT_ACTIVE_LOW}};

    logic [PW-1:0]       prescaler_q, prescaler_d;
    logic [DGW-1:0]      digit_q, digit_d;
    logic [CW-1:0]       cur_ch_q, cur_ch_d;
    logic [DW-1:0]       snap_q, snap_d;
    logic [N_DIGITS-1:0] seg_an_q, seg_an_d;
    logic [7:0]          seg_cat_q, seg_cat_d;

    logic                wrap;
    logic                press;
    logic                dp;
    logic [DW-1:0]       sel_word;
    logic [3:0]          nibble;
    logic [N_DIGITS-1:0] an_hi;
    logic [7:0]          cat_hi;

    gb_btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn_next),
        .level   (bus.btn_level),
        .press   (press),
        .state   (bus.btn_state)
    );

    always_comb begin
        wrap        = (prescaler_q == PS_LAST);
        prescaler_d = wrap ? '0 : prescaler_q + 1'b1;

        digit_d = digit_q;
        if (wrap) digit_d = (digit_q == DG_LAST) ? '0 : digit_q + 1'b1;

        cur_ch_d = cur_ch_q;
        if (press) cur_ch_d = (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + 1'b1;

        // Snapshot follows the registered channel, so a new selection shows one cycle later.
        sel_word = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cur_ch_q == CW'(k)) sel_word = bus.ch_data[k*DW +: DW];
        end
        snap_d = bus.freeze ? snap_q : sel_word;

        nibble = '0;
        an_hi  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_q == DGW'(i)) begin
                nibble   = snap_q[i*4 +: 4];
                an_hi[i] = 1'b1;
            end
        end
        if (prescaler_q < BLANK_LIM) an_hi = '0;

        dp = ((digit_q == '0) && bus.freeze) || ((digit_q == DG_LAST) && cur_ch_q[0]);

        cat_hi                = '0;
        cat_hi[SEG_G:SEG_A]   = hex_to_seg(nibble);
        cat_hi[SEG_DP]        = dp;

        seg_an_d  = an_hi ^ AN_OFF;
        seg_cat_d = cat_hi ^ CAT_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q <= '0;
            digit_q     <= '0;
            cur_ch_q    <= '0;
            snap_q      <= '0;
            seg_an_q    <= AN_OFF;
            seg_cat_q   <= CAT_OFF;
        end else begin
            prescaler_q <= prescaler_d;
            digit_q     <= digit_d;
            cur_ch_q    <= cur_ch_d;
            snap_q      <= snap_d;
            seg_an_q    <= seg_an_d;
            seg_cat_q   <= seg_cat_d;
        end
    end

    assign bus.seg_an  = seg_an_q;
    assign bus.seg_cat = seg_cat_q;
    assign bus.cur_ch  = cur_ch_q;

endmodule

// File: tb/tb_gb_debug_display.sv
// Bench for gb_debug_display: an active-low and an active-high instance run side by
// side and are compared against a cycle-position model of the scanned display.
module tb_gb_debug_display;
    import gb_dbg_pkg::*;

    localparam int ND = 4;
    localparam int NC = 3;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int DB = 3;

    // Standard hex font, bit 0 = a ... bit 6 = g, lowercase b and d.
    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NC*16-1:0] chans = '0;
    logic             btn   = 1'b0;
    logic             frz   = 1'b0;
    int               m_ch  = 0;
    logic [15:0]      hold_val = '0;
    int               cyc   = 0;
    int               checks = 0;
    int               errors = 0;
    logic [11:0]      exp_q[$];

    gb_debug_display_if #(.N_DIGITS(ND), .N_CH(NC)) bus_a ();
    gb_debug_display_if #(.N_DIGITS(ND), .N_CH(NC)) bus_b ();

    assign bus_a.ch_data  = chans;
    assign bus_a.btn_next = btn;
    assign bus_a.freeze   = frz;
    assign bus_b.ch_data  = chans;
    assign bus_b.btn_next = btn;
    assign bus_b.freeze   = frz;

    gb_debug_display #(
        .N_DIGITS(ND), .N_CH(NC), .SCAN_DIV(SD), .BLANK_CYC(BC), .DEBOUNCE_CYC(DB),
        .AN_ACTIVE_LOW(1'b1), .CAT_ACTIVE_LOW(1'b1)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    gb_debug_display #(
        .N_DIGITS(ND), .N_CH(NC), .SCAN_DIV(SD), .BLANK_CYC(BC), .DEBOUNCE_CYC(DB),
        .AN_ACTIVE_LOW(1'b0), .CAT_ACTIVE_LOW(1'b0)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Edges since the last reset edge; the display position is derived from this alone.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Expected {seg_an, seg_cat} sampled after edge n: the outputs show the
    // slot position that was current during the n-th cycle after reset.
    function automatic logic [11:0] ref_frame(input int n, input logic [15:0] val,
                                              input bit fz, input int ch, input bit al);
        logic [3:0] an;
        logic [7:0] cat;
        logic [3:0] nib;
        int pos, dig;
        an  = '0;
        cat = '0;
        if (n > 0) begin
            pos = (n - 1) % SD;
            dig = ((n - 1) / SD) % ND;
            nib = 4'(val >> (4 * dig));
            an  = (pos < BC) ? 4'b0000 : 4'(1 << dig);
            cat = {((dig == 0) && fz) || ((dig == ND - 1) && (ch % 2 == 1)), FONT[nib]};
        end
        if (al) begin
            an  = ~an;
            cat = ~cat;
        end
        return {an, cat};
    endfunction

    function automatic logic [15:0] shown();
        return frz ? hold_val : chans[m_ch*16 +: 16];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        btn = 1'b0;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        m_ch = 0;
    endtask

    task automatic press_button(input int hold);
        btn = 1'b1;
        repeat (hold) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_a.seg_an !== 4'hF || bus_a.seg_cat !== 8'hFF) begin
            errors++;
            $display("FAIL reset_a an=%b cat=%b want 1111/11111111", bus_a.seg_an, bus_a.seg_cat);
        end
        checks++;
        if (bus_b.seg_an !== 4'h0 || bus_b.seg_cat !== 8'h00) begin
            errors++;
            $display("FAIL reset_b an=%b cat=%b want 0000/00000000", bus_b.seg_an, bus_b.seg_cat);
        end
        checks++;
        if (bus_a.cur_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_ch got %0d want 0", bus_a.cur_ch);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_a.seg_an !== 4'hF) begin
            errors++;
            $display("FAIL first_slot_blank an=%b want 1111", bus_a.seg_an);
        end
    endtask

    task automatic test_scan();
        logic [11:0] exp;
        for (int it = 0; it < 3; it++) begin
            chans[15:0] = (it == 0) ? 16'h1A2F : 16'($urandom);
            repeat (3) @(negedge clk);
            for (int k = 1; k <= 2 * ND * SD; k++) exp_q.push_back(ref_frame(cyc + k, shown(), frz, m_ch, 1'b1));
            for (int k = 1; k <= 2 * ND * SD; k++) begin
                @(negedge clk);
                exp = exp_q.pop_front();
                checks++;
                if ({bus_a.seg_an, bus_a.seg_cat} !== exp) begin
                    errors++;
                    $display("FAIL scan_a n=%0d got %h want %h", cyc, {bus_a.seg_an, bus_a.seg_cat}, exp);
                end
                exp = ref_frame(cyc, shown(), frz, m_ch, 1'b0);
                checks++;
                if ({bus_b.seg_an, bus_b.seg_cat} !== exp) begin
                    errors++;
                    $display("FAIL scan_b n=%0d got %h want %h", cyc, {bus_b.seg_an, bus_b.seg_cat}, exp);
                end
            end
        end
    endtask

    task automatic test_polarity();
        bit found;
        found = 1'b0;
        chans[15:0] = 16'h0008;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4 * ND * SD && !found; k++) begin
            @(negedge clk);
            if (((cyc - 1) % SD) >= BC && (((cyc - 1) / SD) % ND) == 0) begin
                found = 1'b1;
                checks++;
                if (bus_b.seg_an !== 4'b0001 || bus_b.seg_cat !== 8'b0111_1111) begin
                    errors++;
                    $display("FAIL polarity an=%b cat=%b want 0001/01111111", bus_b.seg_an, bus_b.seg_cat);
                end
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL polarity_timeout no digit-0 slot seen");
        end
    endtask

    task automatic test_debounce();
        bit bad;
        int seen;
        bad = 1'b0;
        btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (bus_a.cur_ch !== 2'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL glitch_ignored cur_ch=%0d want 0", bus_a.cur_ch);
        end
        // Clean 6-cycle press: nothing may be accepted before 2 sync + 3 stable edges.
        seen = 0;
        btn = 1'b1;
        for (int k = 1; k <= 16 && seen == 0; k++) begin
            @(negedge clk);
            if (k == 6) btn = 1'b0;
            if (k == 4) begin
                checks++;
                if (bus_a.cur_ch !== 2'd0) begin
                    errors++;
                    $display("FAIL press_early cur_ch=%0d want 0", bus_a.cur_ch);
                end
            end
            if (bus_a.cur_ch === 2'd1) seen = k;
        end
        btn = 1'b0;
        checks++;
        if (seen < 5 || seen > 8) begin
            errors++;
            $display("FAIL press_latency edges=%0d want 5..8", seen);
        end
        m_ch = 1;
        bad = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (bus_a.cur_ch !== 2'd1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL press_once cur_ch=%0d want 1", bus_a.cur_ch);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] exp;
        do_reset();
        chans = {16'hBEEF, 16'($urandom), 16'($urandom)};
        for (int p = 1; p <= 3; p++) begin
            press_button(6);
            m_ch = p % NC;
            checks++;
            if (bus_a.cur_ch !== 2'(m_ch)) begin
                errors++;
                $display("FAIL wrap_seq press=%0d cur_ch=%0d want %0d", p, bus_a.cur_ch, m_ch);
            end
            if (m_ch != 0) begin
                repeat (ND * SD) begin
                    @(negedge clk);
                    exp = ref_frame(cyc, shown(), frz, m_ch, 1'b1);
                    checks++;
                    if ({bus_a.seg_an, bus_a.seg_cat} !== exp) begin
                        errors++;
                        $display("FAIL wrap_disp ch=%0d n=%0d got %h want %h", m_ch, cyc,
                                 {bus_a.seg_an, bus_a.seg_cat}, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_freeze();
        logic [11:0] exp;
        do_reset();
        chans = {16'h3333, 16'hC0DE, 16'h0100};
        repeat (3) @(negedge clk);
        frz      = 1'b1;
        hold_val = 16'h0100;
        @(negedge clk);
        chans[15:0] = 16'h0200;
        for (int ph = 0; ph < 3; ph++) begin
            // ph 0: frozen; ph 1: channel advanced while frozen; ph 2: after unfreeze.
            if (ph == 1) begin
                press_button(6);
                m_ch = 1;
                checks++;
                if (bus_a.cur_ch !== 2'd1) begin
                    errors++;
                    $display("FAIL freeze_press cur_ch=%0d want 1", bus_a.cur_ch);
                end
            end
            if (ph == 2) begin
                frz = 1'b0;
                @(negedge clk);
            end else begin
                repeat (2) @(negedge clk);
            end
            repeat (ND * SD) begin
                @(negedge clk);
                exp = ref_frame(cyc, shown(), frz, m_ch, 1'b1);
                checks++;
                if ({bus_a.seg_an, bus_a.seg_cat} !== exp) begin
                    errors++;
                    $display("FAIL freeze_disp ph=%0d n=%0d got %h want %h", ph, cyc,
                             {bus_a.seg_an, bus_a.seg_cat}, exp);
                end
            end
        end
        frz = 1'b0;
        m_ch = 0;
        do_reset();
        repeat (3) @(negedge clk);
        repeat (ND * SD) begin
            @(negedge clk);
            exp = ref_frame(cyc, 16'h0200, 1'b0, 0, 1'b1);
            checks++;
            if ({bus_a.seg_an, bus_a.seg_cat} !== exp) begin
                errors++;
                $display("FAIL unfreeze_ch0 n=%0d got %h want %h", cyc, {bus_a.seg_an, bus_a.seg_cat}, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        do_reset();
        press_button(6);
        checks++;
        if (bus_a.cur_ch !== 2'd1) begin
            errors++;
            $display("FAIL midrst_setup cur_ch=%0d want 1", bus_a.cur_ch);
        end
        btn = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        btn = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_a.cur_ch !== 2'd0 || bus_a.seg_an !== 4'hF || bus_a.seg_cat !== 8'hFF) begin
            errors++;
            $display("FAIL midrst_state ch=%0d an=%b cat=%b want 0/1111/11111111",
                     bus_a.cur_ch, bus_a.seg_an, bus_a.seg_cat);
        end
        rst  = 1'b0;
        m_ch = 0;
        bad  = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (bus_a.cur_ch !== 2'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midrst_no_press cur_ch=%0d want 0", bus_a.cur_ch);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_polarity();
        test_debounce();
        test_wrap();
        test_freeze();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gb_debug_display.md
Name: gb_debug_display

Overview:
- Parametrised debug-display engine for the FPGA top level.
- Selects one of N_CH CPU debug words (PC, IR, address bus, data bus, etc.) and shows it as hex on a multiplexed N_DIGITS 7-segment display.
- Adds per-digit scan with anti-ghost blanking, a debounced channel-select button, and a freeze (snapshot-hold) mode.
- Sits beside the CPU and memory interface; replaces the ad-hoc LED/segment assignments.

Parameters:
- N_DIGITS, 4, number of hex digits/anodes; display word width DW = 4*N_DIGITS.
- N_CH, 4, number of selectable debug channels (>=1); CW = max(1, clog2(N_CH)).
- SCAN_DIV, 50000, clk cycles per digit slot (>=2).
- BLANK_CYC, 500, cycles at the start of each slot with all anodes off (< SCAN_DIV).
- DEBOUNCE_CYC, 1000000, cycles the synchronised button must be stable before it is accepted (>=1).
- AN_ACTIVE_LOW, 1, anode polarity.
- CAT_ACTIVE_LOW, 1, cathode polarity.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- ch_data  in  N_CH*DW  packed channels; channel k = ch_data[k*DW +: DW].
- btn_next  in  1  raw asynchronous push-button; advances channel.
- freeze  in  1  1 = hold current snapshot, 0 = track live data.
- seg_an  out  N_DIGITS  anode enables (polarity per AN_ACTIVE_LOW).
- seg_cat  out  8  {dp,g,f,e,d,c,b,a} (polarity per CAT_ACTIVE_LOW).
- cur_ch  out  CW  currently selected channel index.

Behaviour:
- One clock; reset is synchronous and active-high; all state is clocked on clk posedge.
- Reset values:
  - prescaler=0, digit=0, cur_ch=0, snapshot=0, debounce state idle/level 0.
  - seg_an all inactive; seg_cat all segments off.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, digit increments; digit wraps N_DIGITS-1 -> 0.
- Snapshot:
  - When freeze=0, snapshot <= ch_data[cur_ch] every cycle.
  - When freeze=1, snapshot holds its value.
  - Channel change while frozen: snapshot still holds; the new channel appears after freeze drops.
- Digit mapping:
  - Digit i shows snapshot[4i+3:4i]; digit 0 is the rightmost/LSB nibble.
  - Hex encoding is 0-F standard (b and d in lowercase form).
- Decimal point:
  - dp lit on digit 0 iff freeze=1.
  - dp lit on digit N_DIGITS-1 iff cur_ch is odd (channel parity hint).
  - Both conditions can apply at once.
- Output timing:
  - seg_an and seg_cat are registered, so they reflect prescaler/digit state with 1-cycle latency.
  - While prescaler < BLANK_CYC: seg_an all inactive; seg_cat still driven with the current digit pattern.
  - Otherwise: exactly one anode active (bit digit).
- Button path:
  - 2-FF synchroniser, then a debounce FSM with states STABLE and CHECK.
  - STABLE: sampled != accepted level -> CHECK, counter=0.
  - CHECK: sampled reverts -> STABLE, counter cleared. Counter reaches DEBOUNCE_CYC-1 with sample unchanged -> accepted level updates, back to STABLE.
  - An accepted 0->1 transition produces a single-cycle press pulse.
- Channel select:
  - Press pulse: cur_ch <= (cur_ch==N_CH-1) ? 0 : cur_ch+1.
  - N_CH=1: cur_ch stays 0.
- Simultaneous events:
  - Press and prescaler wrap in the same cycle are both applied.
  - Snapshot follows the new cur_ch from the next cycle.
- Reset mid-operation: any state (mid-debounce, mid-slot) returns to reset values on the next edge; no press is generated by reset.
- Polarity: active level = ~AN_ACTIVE_LOW for anodes and ~CAT_ACTIVE_LOW for segments; inactive is the complement.

Decomposition:
- Package gb_dbg_pkg holds:
  - hex-to-7-seg constant function (active-high, bit order a..g);
  - segment bit-index localparams (SEG_A..SEG_DP);
  - clog2 helper.
- One sub-module, gb_btn_debounce: synchroniser + debounce FSM, parameter DEBOUNCE_CYC, ports clk/rst/btn_raw/level/press.

Test Plan:
- Scan check (N_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, ch0=16'h1A2F, freeze=0), active-low polarity:
  - Each slot shows 1 blank cycle (seg_an=4'b1111), then 3 cycles of one active anode.
  - Sequence: seg_an=4'b1110 with cat for "F", 4'b1101 "2", 4'b1011 "A", 4'b0111 "1", then repeat.
- Debounce (DEBOUNCE_CYC=3):
  - 2-cycle glitch on btn_next -> cur_ch stays 0.
  - Clean 6-cycle press -> cur_ch=1 exactly once, counted 2 sync + 3 stable cycles after the rising edge.
- Wrap (N_CH=3): 3 accepted presses -> cur_ch sequence 1, 2, 0; ch2=16'hBEEF is displayed while cur_ch=2.
- Freeze:
  - freeze=1 while ch0=16'h0100, then ch0 changes to 16'h0200 -> display stays 0100 and dp is lit on digit 0.
  - freeze=0 -> display shows 0200 within 1 cycle of data plus 1 output cycle.
- Reset mid-CHECK: assert rst during the debounce count -> cur_ch=0, all anodes inactive, cat all off next edge; no press pulse after release.
- Polarity (AN_ACTIVE_LOW=0, CAT_ACTIVE_LOW=0): digit 0 value 8 -> seg_an=4'b0001, seg_cat=8'b0111_1111.
